// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer.
// The master drives requests and consumes results. The slave is the sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             busy;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter/rotator that applies up to 2**STEP_W-1 bits per clock on one narrow stage.
// Define SHIFT_ROTATE_EN to support ROL/ROR. Without it, both rotate modes return an error.
module shift_sequencer #(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 5,
  parameter int STEP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  shift_sequencer_if.slave bus
);

  localparam int MAX_STEP = (2 ** STEP_W) - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef enum logic [2:0] {
    MODE_SLL = 3'd0,
    MODE_ROL = 3'd1,
    MODE_SRL = 3'd2,
    MODE_SRA = 3'd3,
    MODE_ROR = 3'd4
  } mode_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    data_q;
  logic [AMT_W-1:0]    rem_q;
  mode_t               mode_q;
  logic                sign_q;
  logic                err_q;

  logic                accept;
  logic                req_legal;
  logic [STEP_W-1:0]   step;
  logic [WIDTH-1:0]    stepped;

  function automatic logic mode_legal(input logic [2:0] m);
    case (m)
      3'd0, 3'd2, 3'd3: return 1'b1;
`ifdef SHIFT_ROTATE_EN
      3'd1, 3'd4:       return 1'b1;
`endif
      default:          return 1'b0;
    endcase
  endfunction

  assign req_legal = mode_legal(bus.in_mode);

  // Amount moved by the barrel stage this cycle: whatever is left, capped at the stage limit.
  always_comb begin
    if (rem_q > AMT_W'(MAX_STEP)) step = STEP_W'(MAX_STEP);
    else                          step = rem_q[STEP_W-1:0];
  end

  // One pass through the narrow stage. Rotates wrap across the whole word.
  always_comb begin
    logic [WIDTH-1:0] sh_l, sh_r, fill;
    sh_l = data_q << step;
    sh_r = data_q >> step;
    fill = ~({WIDTH{1'b1}} >> step);
    stepped = data_q;
    case (mode_q)
      MODE_SLL: stepped = sh_l;
      MODE_SRL: stepped = sh_r;
      MODE_SRA: stepped = sh_r | (sign_q ? fill : '0);
`ifdef SHIFT_ROTATE_EN
      MODE_ROL: stepped = sh_l | (data_q >> (WIDTH - int'(step)));
      MODE_ROR: stepped = sh_r | (data_q << (WIDTH - int'(step)));
`endif
      default:  stepped = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <=, so every flop in this block samples the pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: each output gets a default before the case. This way no path leaves a value held and no latch is inferred.
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = (!req_legal || bus.in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (rem_q == AMT_W'(step)) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      rem_q  <= '0;
      mode_q <= MODE_SLL;
      sign_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      data_q <= bus.in_data;
      rem_q  <= bus.in_amt;
      mode_q <= mode_t'(bus.in_mode);
      sign_q <= bus.in_data[WIDTH-1];
      err_q  <= ~req_legal;
    end else if (state_q == SHIFT) begin
      data_q <= stepped;
      rem_q  <= rem_q - AMT_W'(step);
    end
  end

  // The data and error registers stay frozen through DONE, so the result holds under backpressure.
  assign bus.out_data = data_q;
  assign bus.out_err  = err_q;

endmodule
